nios2_data_read_in: RTL and testbench

- Avalon-MM input PIO slave: the CPU-read counterpart of the existing output PIO.
- Samples an external WIDTH-bit bus through a 2-flop synchronizer and exposes it as a readable data register.
- Captures selected edges per bit into a sticky edge-capture register and raises a maskable level interrupt.
- Sits on the Nios II data master alongside the output PIOs; irq connects to the CPU interrupt controller.

---
 rtl/nios2_data_read_in.sv | 109 ++++++++++
 tb/tb_nios2_data_read_in.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_data_read_in.sv
// Avalon-MM input PIO slave: synchronized input data register, sticky
// per-bit edge capture with write-1-to-clear, and a maskable interrupt.
module nios2_data_read_in #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EDGE_TYPE = 0,
    parameter int unsigned IRQ_TYPE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic             read_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned ARM_W = 2;
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(3);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_inputs;

    // Reads have no side effects, so the read strobe is intentionally ignored.
    assign unused_inputs = ^{read_n, writedata};

    assign armed = (arm_cnt == ARM_MAX);
    assign wr_en = chipselect & ~write_n;

    // Per-bit edge selection, suppressed while the synchronizer refills after reset.
    always_comb begin
        edge_vec = '0;
        if (armed) begin
            case (EDGE_TYPE)
                0:       edge_vec = s2 & ~s3;
                1:       edge_vec = ~s2 & s3;
                default: edge_vec = s2 ^ s3;
            endcase
        end
    end

    // Write-1-to-clear mask for the edge capture register.
    always_comb begin
        clr_vec = '0;
        if (wr_en && address == 2'd3) begin
            clr_vec = writedata[WIDTH-1:0];
        end
    end

    // Register read mux; reserved and unused upper bits read zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(s2);
            2'd2:    rd_mux = 32'(irq_mask);
            2'd3:    rd_mux = 32'(edge_capture);
            default: rd_mux = '0;
        endcase
    end

    // Interrupt from either masked live data or masked captured edges.
    always_comb begin
        irq = 1'b0;
        if (IRQ_TYPE == 0) begin
            irq = |(s2 & irq_mask);
        end else begin
            irq = |(edge_capture & irq_mask);
        end
    end

    // Synchronizer, arm counter, control registers and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1           <= '0;
            s2           <= '0;
            s3           <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            arm_cnt      <= '0;
        end else begin
            s1           <= in_port;
            s2           <= s1;
            s3           <= s2;
            readdata     <= rd_mux;
            // A new edge on a bit being cleared in the same cycle is kept.
            edge_capture <= (edge_capture & ~clr_vec) | edge_vec;
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nios2_data_read_in.sv
// Testbench for nios2_data_read_in: three differently parameterised instances
// share one bus; a sample-history reference model feeds a read scoreboard.
module tb_nios2_data_read_in;

    localparam int NI = 3;
    localparam int unsigned ET [NI] = '{0, 2, 1};
    localparam int unsigned IT [NI] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        read_n;
    logic [31:0] in_port;
    logic [31:0] rdata [NI];
    logic        irq_o [NI];

    logic [31:0] wm [NI];
    logic [31:0] hist [$];
    logic [31:0] m_ec [NI];
    logic [31:0] m_mask [NI];
    logic [31:0] expq [NI][$];
    logic        exp_irq [NI];
    bit          rd_pend = 1'b0;
    bit          chk_en  = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nios2_data_read_in #(.WIDTH(32), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .in_port(in_port), .readdata(rdata[0]), .irq(irq_o[0]));

    nios2_data_read_in #(.WIDTH(32), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .in_port(in_port), .readdata(rdata[1]), .irq(irq_o[1]));

    nios2_data_read_in #(.WIDTH(12), .EDGE_TYPE(1), .IRQ_TYPE(0)) u_lvl (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .in_port(in_port[11:0]), .readdata(rdata[2]), .irq(irq_o[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] edge_of(input int unsigned et, input logic [31:0] cur,
                                            input logic [31:0] prev);
        case (et)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    // Reference model: values sampled after reset are kept as a history; the
    // data register shows the sample from one edge back, and an edge between
    // two consecutive post-reset samples lands in the capture register two
    // edges after the later sample.
    always @(posedge clk) begin : model
        logic [31:0] d_pre, d_post, newe, clr;
        int sz;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < NI; i++) begin
                m_ec[i] = '0;
                m_mask[i] = '0;
                expq[i].push_back(32'h0);
            end
            rd_pend = 1'b1;
            chk_en  = 1'b1;
        end else begin
            sz = hist.size();
            d_pre = (sz >= 2) ? hist[sz-2] : 32'h0;
            rd_pend = chipselect && !read_n;
            for (int i = 0; i < NI; i++) begin
                if (rd_pend) begin
                    case (address)
                        2'd0:    expq[i].push_back(d_pre & wm[i]);
                        2'd2:    expq[i].push_back(m_mask[i]);
                        2'd3:    expq[i].push_back(m_ec[i]);
                        default: expq[i].push_back(32'h0);
                    endcase
                end
                newe = (sz >= 3) ? (edge_of(ET[i], hist[sz-2], hist[sz-3]) & wm[i]) : 32'h0;
                clr  = (chipselect && !write_n && address == 2'd3) ? (writedata & wm[i]) : 32'h0;
                m_ec[i] = (m_ec[i] & ~clr) | newe;
                if (chipselect && !write_n && address == 2'd2) m_mask[i] = writedata & wm[i];
            end
            hist.push_back(in_port);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        sz = hist.size();
        d_post = (sz >= 2) ? hist[sz-2] : 32'h0;
        for (int i = 0; i < NI; i++) begin
            exp_irq[i] = (IT[i] == 0) ? |(d_post & wm[i] & m_mask[i]) : |(m_ec[i] & m_mask[i]);
        end
    end

    // Monitor: compares read responses against the scoreboard and irq every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                if (rd_pend) begin
                    if (expq[i].size() == 0) begin
                        check($sformatf("sb_empty%0d", i), 32'h1, 32'h0);
                    end else begin
                        check($sformatf("readdata%0d", i), rdata[i], expq[i].pop_front());
                    end
                end
                check($sformatf("irq%0d", i), 32'(irq_o[i]), 32'(exp_irq[i]));
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        cyc();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic rd_chk(input logic [1:0] a, input int inst, input logic [31:0] mask,
                          input logic [31:0] exp, input string nm);
        bus_read(a);
        @(negedge clk);
        check(nm, rdata[inst] & mask, exp);
        cyc();
    endtask

    initial begin
        wm = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0FFF};
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; read_n = 1'b1; in_port = 32'hFFFF_FFFF;
        cyc(3);
        reset = 1'b0;
        cyc(10);

        // Inputs held high through reset: data visible, no capture, no irq.
        rd_chk(2'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "data_after_reset");
        rd_chk(2'd0, 2, 32'hFFFF_FFFF, 32'h0000_0FFF, "data_narrow");
        rd_chk(2'd3, 0, 32'hFFFF_FFFF, 32'h0, "ec_after_reset");
        check("irq_after_reset", 32'(irq_o[0]), 32'h0);

        // Rising edge on bit0 with mask bit0: capture latency and W1C.
        in_port = 32'h0;
        cyc(4);
        bus_write(2'd2, 32'h1);
        bus_write(2'd3, 32'hFFFF_FFFF);
        cyc(4);
        in_port = 32'h1;
        cyc(2);
        check("irq_before_capture", 32'(irq_o[0]), 32'h0);
        cyc();
        check("irq_on_capture", 32'(irq_o[0]), 32'h1);
        rd_chk(2'd3, 0, 32'hFFFF_FFFF, 32'h1, "ec_bit0");
        bus_write(2'd3, 32'h1);
        check("irq_after_clear", 32'(irq_o[0]), 32'h0);
        rd_chk(2'd3, 0, 32'hFFFF_FFFF, 32'h0, "ec_cleared");

        // Edge on bit5 landing in the same cycle as its W1C write: set wins.
        in_port = 32'h21;
        cyc(4);
        in_port = 32'h1;
        cyc(4);
        in_port = 32'h21;
        cyc(2);
        bus_write(2'd3, 32'h20);
        rd_chk(2'd3, 0, 32'h20, 32'h20, "ec_set_wins");

        // Any-edge instance: falling bit3 captured, irq gated by mask.
        in_port = 32'h29;
        cyc(4);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h0);
        in_port = 32'h21;
        cyc(4);
        rd_chk(2'd3, 1, 32'hFFFF_FFFF, 32'h8, "ec_any_fall");
        check("irq_masked", 32'(irq_o[1]), 32'h0);
        bus_write(2'd2, 32'h8);
        check("irq_unmasked", 32'(irq_o[1]), 32'h1);

        // Level-interrupt instance follows masked data with two-cycle latency.
        bus_write(2'd2, 32'h100);
        in_port = 32'h100;
        cyc();
        check("lvl_irq_wait", 32'(irq_o[2]), 32'h0);
        cyc();
        check("lvl_irq_high", 32'(irq_o[2]), 32'h1);
        in_port = 32'h0;
        cyc(2);
        check("lvl_irq_low", 32'(irq_o[2]), 32'h0);

        // Reserved read, ignored data write, then reset with an edge in flight.
        rd_chk(2'd1, 0, 32'hFFFF_FFFF, 32'h0, "reserved_read");
        bus_write(2'd0, 32'h1234_5678);
        in_port = 32'hA5;
        cyc(3);
        rd_chk(2'd0, 0, 32'hFFFF_FFFF, 32'hA5, "data_tracks");
        in_port = 32'h5A;
        cyc();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) rd_chk(2'd3, 1, 32'hFFFF_FFFF, 32'h0, "ec_post_reset");
        rd_chk(2'd2, 1, 32'hFFFF_FFFF, 32'h0, "mask_post_reset");

        // Randomized traffic checked entirely by the scoreboard.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3, 0) == 0) in_port = $urandom();
            reset = ($urandom_range(249, 0) == 0);
            address = 2'($urandom_range(3, 0));
            writedata = ($urandom_range(1, 0) == 0) ? $urandom() : 32'($urandom_range(255, 0));
            case ($urandom_range(5, 0))
                0, 1: begin chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; end
                2:    begin chipselect = 1'b1; read_n = 1'b1; write_n = 1'b0; end
                3:    begin chipselect = 1'b0; read_n = 1'b0; write_n = 1'b0; end
                default: begin chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; end
            endcase
            cyc();
        end
        reset = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        cyc(3);
        for (int i = 0; i < NI; i++) check($sformatf("sb_drain%0d", i), 32'(expq[i].size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
